// File: rtl/sim_sched_pkg.sv
// Shared constants, FSM state encoding, result record and helpers for the sweep scheduler.
package sim_sched_pkg;

    localparam int unsigned STATE      = 32;
    localparam int unsigned LOG_RULES  = 5;
    localparam int unsigned MAX_KO     = 16;
    localparam int unsigned MAX_ITER   = 1000;
    localparam int unsigned RST_CYCLES = 2;
    localparam int unsigned ITER_W     = 10;

    localparam int unsigned KO_W  = $clog2(MAX_KO);
    localparam int unsigned RUN_W = KO_W + 1;
    localparam int unsigned RC_W  = $clog2(RST_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE,
        DPRST,
        INHIB,
        START,
        WAIT,
        REPORT,
        NEXT,
        DONE,
        ABORT_RST
    } state_t;

    typedef struct packed {
        logic [RUN_W-1:0]  run;
        logic [STATE-1:0]  state;
        logic [ITER_W-1:0] iter;
        logic              timeout;
    } result_t;

    // Limit the requested knockout count to the list depth.
    function automatic logic [RUN_W-1:0] clamp_ko(input logic [RUN_W-1:0] n);
        return (n > RUN_W'(MAX_KO)) ? RUN_W'(MAX_KO) : n;
    endfunction

endpackage

// File: rtl/sim_sweep_scheduler_ko_list_ram.sv
// Knockout list storage: MAX_KO x LOG_RULES register file.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous read.
// Contents are intentionally not reset so the list survives a sweep reset.
module ko_list_ram
    import sim_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [KO_W-1:0]      waddr,
    input  logic [LOG_RULES-1:0] wdata,
    input  logic [KO_W-1:0]      raddr,
    output logic [LOG_RULES-1:0] rdata
);

    logic [LOG_RULES-1:0] mem [MAX_KO];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sim_sweep_scheduler.sv
// Run-level controller for a knockout sweep over the simulation datapath.
// Run 0 is the uninhibited baseline; run k inhibits knock_list[k-1].
// Ports: clk/rst; go/abort/num_ko sweep control; cfg_* list write;
//   dp_* datapath control and status; res_* result record handshake;
//   busy level and done pulse. All outputs are registered.
module sim_sweep_scheduler
    import sim_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [RUN_W-1:0]     num_ko,
    input  logic                 cfg_we,
    input  logic [KO_W-1:0]      cfg_addr,
    input  logic [LOG_RULES-1:0] cfg_sel,
    output logic                 dp_rst,
    output logic                 dp_start,
    output logic                 dp_ld_inhibitor,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    input  logic [STATE-1:0]     dp_network_state,
    input  logic                 dp_steady_state,
    input  logic [ITER_W-1:0]    dp_iteration_number,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RUN_W-1:0]     res_run,
    output logic [STATE-1:0]     res_state,
    output logic [ITER_W-1:0]    res_iter,
    output logic                 res_timeout,
    output logic                 busy,
    output logic                 done
);

    state_t               state_q, state_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [RUN_W-1:0]     num_ko_q, num_ko_d;
    logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic                 first_q, first_d;
    result_t              res_q, res_d;
    logic                 dp_rst_d, dp_start_d, dp_ld_d, res_valid_d, busy_d, done_d;
    logic [LOG_RULES-1:0] sel_d;
    logic [LOG_RULES-1:0] ko_sel;

    // List writes are only accepted between sweeps.
    ko_list_ram u_ko_list (
        .clk   (clk),
        .we    (cfg_we & ~busy),
        .waddr (cfg_addr),
        .wdata (cfg_sel),
        .raddr (KO_W'(run_q - RUN_W'(1))),
        .rdata (ko_sel)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            run_q            <= '0;
            num_ko_q         <= '0;
            rst_cnt_q        <= '0;
            first_q          <= 1'b0;
            res_q            <= '0;
            dp_rst           <= 1'b0;
            dp_start         <= 1'b0;
            dp_ld_inhibitor  <= 1'b0;
            dp_sel_inhibitor <= '0;
            res_valid        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_q          <= state_d;
            run_q            <= run_d;
            num_ko_q         <= num_ko_d;
            rst_cnt_q        <= rst_cnt_d;
            first_q          <= first_d;
            res_q            <= res_d;
            dp_rst           <= dp_rst_d;
            dp_start         <= dp_start_d;
            dp_ld_inhibitor  <= dp_ld_d;
            dp_sel_inhibitor <= sel_d;
            res_valid        <= res_valid_d;
            busy             <= busy_d;
            done             <= done_d;
        end
    end

    // Next-state, counters, capture, and next output values.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        num_ko_d  = num_ko_q;
        rst_cnt_d = rst_cnt_q;
        first_d   = first_q;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                if (go) begin
                    num_ko_d  = clamp_ko(num_ko);
                    run_d     = '0;
                    rst_cnt_d = '0;
                    state_d   = DPRST;
                end
            end
            DPRST: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = (run_q != '0) ? INHIB : START;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            INHIB: state_d = START;
            START: begin
                first_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                first_d = 1'b0;
                // The comparator output is stale on the first WAIT cycle.
                if (!first_q) begin
                    if (dp_steady_state || (dp_iteration_number >= ITER_W'(MAX_ITER))) begin
                        res_d.run     = run_q;
                        res_d.state   = dp_network_state;
                        res_d.iter    = dp_iteration_number;
                        res_d.timeout = ~dp_steady_state;
                        state_d       = REPORT;
                    end
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (run_q == num_ko_q) begin
                    state_d = DONE;
                end else begin
                    run_d     = run_q + RUN_W'(1);
                    rst_cnt_d = '0;
                    state_d   = DPRST;
                end
            end
            DONE: state_d = IDLE;
            ABORT_RST: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides every transition; the aborted run leaves no trace.
        if (abort && (state_q != IDLE) && (state_q != ABORT_RST)) begin
            state_d   = ABORT_RST;
            rst_cnt_d = '0;
            run_d     = run_q;
            res_d     = res_q;
        end

        dp_rst_d    = (state_d == DPRST) || (state_d == ABORT_RST);
        dp_start_d  = (state_d == START);
        dp_ld_d     = (state_d == INHIB);
        sel_d       = (state_d == INHIB) ? ko_sel : dp_sel_inhibitor;
        res_valid_d = (state_d == REPORT);
        busy_d      = (state_d != IDLE) && (state_d != DONE);
        done_d      = (state_d == DONE);
    end

    assign res_run     = res_q.run;
    assign res_state   = res_q.state;
    assign res_iter    = res_q.iter;
    assign res_timeout = res_q.timeout;

endmodule

// File: tb/tb_sim_sweep_scheduler.sv
// Self-checking bench for sim_sweep_scheduler with a small iteration-counting datapath model.
module tb_sim_sweep_scheduler;
    import sim_sched_pkg::*;

    logic                 clk, rst, go, abort, cfg_we, res_ready;
    logic [RUN_W-1:0]     num_ko;
    logic [KO_W-1:0]      cfg_addr;
    logic [LOG_RULES-1:0] cfg_sel;
    logic                 dp_rst, dp_start, dp_ld_inhibitor;
    logic [LOG_RULES-1:0] dp_sel_inhibitor;
    logic [STATE-1:0]     dp_network_state;
    logic                 dp_steady_state;
    logic [ITER_W-1:0]    dp_iteration_number;
    logic                 res_valid, res_timeout, busy, done;
    logic [RUN_W-1:0]     res_run;
    logic [STATE-1:0]     res_state;
    logic [ITER_W-1:0]    res_iter;

    int total = 0;
    int bad = 0;
    int steady_at = -1;

    sim_sweep_scheduler dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .num_ko(num_ko),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
        .dp_rst(dp_rst), .dp_start(dp_start), .dp_ld_inhibitor(dp_ld_inhibitor),
        .dp_sel_inhibitor(dp_sel_inhibitor), .dp_network_state(dp_network_state),
        .dp_steady_state(dp_steady_state), .dp_iteration_number(dp_iteration_number),
        .res_valid(res_valid), .res_ready(res_ready), .res_run(res_run),
        .res_state(res_state), .res_iter(res_iter), .res_timeout(res_timeout),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: counts iterations after start, steady at a chosen iteration.
    logic [ITER_W-1:0] m_iter;
    logic              m_run;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_iter <= '0;
            m_run  <= 1'b0;
        end else if (dp_rst) begin
            m_iter <= '0;
            m_run  <= 1'b0;
        end else if (dp_start) begin
            m_iter <= '0;
            m_run  <= 1'b1;
        end else if (m_run && (m_iter != 10'h3FF)) begin
            m_iter <= m_iter + 10'd1;
        end
    end
    assign dp_iteration_number = m_iter;
    assign dp_network_state    = {16'hCAFE, 6'd0, m_iter};
    assign dp_steady_state     = (steady_at >= 0) && (int'(m_iter) == steady_at);

    // Event monitor.
    int ld_cnt = 0, last_sel = -1, done_cnt = 0, res_cnt = 0, last_run = -1, last_iter = -1;
    always @(posedge clk) begin
        if (dp_ld_inhibitor) begin
            ld_cnt++;
            last_sel = int'(dp_sel_inhibitor);
        end
        if (done) done_cnt++;
        if (res_valid && res_ready) begin
            res_cnt++;
            last_run  = int'(res_run);
            last_iter = int'(res_iter);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int addr, input int sel);
        cfg_we   = 1'b1;
        cfg_addr = KO_W'(addr);
        cfg_sel  = LOG_RULES'(sel);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_go(input int n);
        num_ko = RUN_W'(n);
        go     = 1'b1;
        tick();
        go     = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while ((done_cnt == base) && (n < 5000)) begin
            tick();
            n++;
        end
        check(name, 64'(done_cnt - base), 64'd1);
    endtask

    typedef struct {
        int steady_at;
        int hold;
        int exp_iter;
        bit exp_to;
        int exp_sel;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int n, ld0, d0, r0;
        logic [STATE-1:0] exp_state;

        rst = 1'b1; go = 1'b0; abort = 1'b0; num_ko = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_sel = '0; res_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dp_rst", 64'(dp_rst), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sel", 64'(dp_sel_inhibitor), 64'd0);
        rst = 1'b0;
        tick();

        cfg_write(0, 3);
        cfg_write(1, 7);
        cfg_write(2, 12);
        cfg_write(3, 31);

        // steady_at, ready hold cycles, expected iter, expected timeout, expected sel (-1: none)
        vecs[0] = '{12,   0, 12,   1'b0, -1};
        vecs[1] = '{0,    0, 1000, 1'b1, 3};   // steady only on the guarded first cycle
        vecs[2] = '{1000, 5, 1000, 1'b0, 7};   // steady and cap together
        vecs[3] = '{5,    0, 5,    1'b0, 12};
        vecs[4] = '{1,    2, 1,    1'b0, 31};

        for (int i = 0; i < 5; i++) begin
            steady_at = vecs[i].steady_at;
            ld0 = ld_cnt;
            if (i == 0) begin
                pulse_go(4);
                check("go_busy", 64'(busy), 64'd1);
            end
            n = 0;
            while (!res_valid && (n < 3000)) begin
                tick();
                n++;
            end
            exp_state = {16'hCAFE, 6'd0, ITER_W'(vecs[i].exp_iter)};
            check($sformatf("v%0d_valid", i), 64'(res_valid), 64'd1);
            check($sformatf("v%0d_run", i), 64'(res_run), 64'(i));
            check($sformatf("v%0d_iter", i), 64'(res_iter), 64'(vecs[i].exp_iter));
            check($sformatf("v%0d_timeout", i), 64'(res_timeout), 64'(vecs[i].exp_to));
            check($sformatf("v%0d_state", i), 64'(res_state), 64'(exp_state));
            check($sformatf("v%0d_ld_cnt", i), 64'(ld_cnt - ld0), (vecs[i].exp_sel < 0) ? 64'd0 : 64'd1);
            if (vecs[i].exp_sel >= 0)
                check($sformatf("v%0d_sel", i), 64'(last_sel), 64'(vecs[i].exp_sel));
            for (int h = 0; h < vecs[i].hold; h++) begin
                tick();
                check($sformatf("v%0d_hold_valid", i), 64'(res_valid), 64'd1);
                check($sformatf("v%0d_hold_iter", i), 64'(res_iter), 64'(vecs[i].exp_iter));
                check($sformatf("v%0d_hold_state", i), 64'(res_state), 64'(exp_state));
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check($sformatf("v%0d_valid_drop", i), 64'(res_valid), 64'd0);
            check($sformatf("v%0d_next_no_rst", i), 64'(dp_rst), 64'd0);
            tick();
            if (i < 4) begin
                check($sformatf("v%0d_dprst", i), 64'(dp_rst), 64'd1);
            end else begin
                check("sweep_done", 64'(done), 64'd1);
                check("sweep_busy_low", 64'(busy), 64'd0);
                tick();
                check("done_one_cycle", 64'(done), 64'd0);
            end
        end

        // Clamp: 20 requested, 17 runs; list write while busy is dropped.
        res_ready = 1'b1;
        steady_at = 1;
        r0 = res_cnt;
        d0 = done_cnt;
        pulse_go(20);
        cfg_write(0, 9);
        wait_done(d0, "clamp_done");
        check("clamp_results", 64'(res_cnt - r0), 64'd17);
        check("clamp_last_run", 64'(last_run), 64'd16);
        tick();
        check("clamp_busy_low", 64'(busy), 64'd0);

        ld0 = ld_cnt;
        d0 = done_cnt;
        pulse_go(1);
        wait_done(d0, "list_done");
        check("list_ld_cnt", 64'(ld_cnt - ld0), 64'd1);
        check("list_unchanged", 64'(last_sel), 64'd3);

        // Abort during WAIT of run 1.
        steady_at = 5;
        r0 = res_cnt;
        d0 = done_cnt;
        pulse_go(2);
        n = 0;
        while ((res_cnt == r0) && (n < 3000)) begin
            tick();
            n++;
        end
        steady_at = -1;
        n = 0;
        while (!dp_start && (n < 100)) begin
            tick();
            n++;
        end
        check("abort_start_seen", 64'(dp_start), 64'd1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rst1", 64'(dp_rst), 64'd1);
        check("abort_valid", 64'(res_valid), 64'd0);
        tick();
        check("abort_rst2", 64'(dp_rst), 64'd1);
        tick();
        check("abort_rst_end", 64'(dp_rst), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (5) tick();
        check("abort_results", 64'(res_cnt - r0), 64'd1);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        steady_at = 3;
        r0 = res_cnt;
        d0 = done_cnt;
        pulse_go(0);
        wait_done(d0, "restart_done");
        check("restart_results", 64'(res_cnt - r0), 64'd1);
        check("restart_run", 64'(last_run), 64'd0);
        check("restart_iter", 64'(last_iter), 64'd3);

        // Async reset mid-WAIT.
        steady_at = -1;
        pulse_go(1);
        repeat (20) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_dp_rst", 64'(dp_rst), 64'd0);
        check("arst_iter", 64'(res_iter), 64'd0);
        check("arst_sel", 64'(dp_sel_inhibitor), 64'd0);
        check("arst_valid", 64'(res_valid), 64'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sim_sweep_scheduler.md
Name: sim_sweep_scheduler

Overview:
- Run-level controller that sits above the synchronous simulation datapath and drives its start, ld_inhibitor/sel_inhibitor and a local datapath reset.
- Executes a knockout sweep: run 0 is the baseline with no inhibition; run k (k ≥ 1) inhibits rule knock_list[k-1].
- Each run waits for steady state or an iteration cap, then hands a result record to a downstream consumer over a valid/ready handshake.

Parameters:
- STATE, 32, width of network state vector.
- LOG_RULES, 5, width of inhibitor select index.
- MAX_KO, 16, depth of knockout list (power of two).
- MAX_ITER, 1000, iteration cap; must be < 1024 (iteration_number is 10 bits).
- RST_CYCLES, 2, length of datapath reset pulse.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- go, in, 1, start sweep; sampled only in IDLE.
- abort, in, 1, synchronous abort of the sweep.
- num_ko, in, $clog2(MAX_KO)+1, number of knockout runs; sampled with go.
- cfg_we, in, 1, knockout-list write strobe.
- cfg_addr, in, $clog2(MAX_KO), list write index.
- cfg_sel, in, LOG_RULES, rule index written.
- dp_rst, out, 1, datapath reset (OR'd with rst at the datapath).
- dp_start, out, 1, start pulse to datapath.
- dp_ld_inhibitor, out, 1, inhibitor load strobe.
- dp_sel_inhibitor, out, LOG_RULES, inhibitor index.
- dp_network_state, in, STATE, datapath network_state.
- dp_steady_state, in, 1, datapath steady flag.
- dp_iteration_number, in, 10, datapath iteration count.
- res_valid, out, 1, result record valid.
- res_ready, in, 1, consumer accepts record.
- res_run, out, $clog2(MAX_KO)+1, run index (0 = baseline).
- res_state, out, STATE, captured final state.
- res_iter, out, 10, iteration count at capture.
- res_timeout, out, 1, run hit MAX_ITER without steady state.
- busy, out, 1, sweep in progress.
- done, out, 1, one-cycle pulse at sweep completion.

Behaviour:
- Reset (async, active-high): FSM to IDLE. All outputs 0, all result registers 0, run counter 0. The knockout list is not cleared.
- All outputs are registered.
- num_ko > MAX_KO is clamped to MAX_KO. Total runs = clamped num_ko + 1.
- cfg_we writes the list only when busy = 0. Writes while busy are dropped.
- FSM transitions:
  - IDLE: go → latch num_ko, run = 0, busy = 1, go to DPRST. go while busy is ignored.
  - DPRST: dp_rst = 1 for exactly RST_CYCLES cycles. Then go to INHIB if run > 0, else START.
  - INHIB: one cycle with dp_ld_inhibitor = 1 and dp_sel_inhibitor = knock_list[run-1], then START. dp_sel_inhibitor holds its value otherwise.
  - START: dp_start = 1 for one cycle, then WAIT.
  - WAIT: the first WAIT cycle ignores dp_steady_state (guard against the stale comparator value).
    - From the second cycle, dp_steady_state = 1 → capture state and iteration count, res_timeout = 0, go to REPORT.
    - Else dp_iteration_number ≥ MAX_ITER → capture with res_timeout = 1, go to REPORT.
    - If both conditions hold in the same cycle, steady wins (res_timeout = 0).
  - REPORT: res_valid = 1 with fields stable until the cycle where res_valid & res_ready. Then res_valid drops the next cycle and the FSM goes to NEXT. Ready may be held high; minimum REPORT occupancy is 1 cycle.
  - NEXT: if run == clamped num_ko → DONE; else run++ and go to DPRST.
  - DONE: done = 1 for one cycle, busy = 0, then IDLE.
- Abort: abort = 1 in any non-IDLE state has priority over all transitions.
  - Drop res_valid, go to DPRST-abort (RST_CYCLES of dp_rst), then IDLE with busy = 0.
  - No done pulse and no result for the aborted run.
  - abort in IDLE is ignored.
- Latency per run = RST_CYCLES + (run > 0) + 1 + WAIT cycles + REPORT cycles + 1.
- The run counter is 5 bits for MAX_KO = 16 and never wraps; clamping guarantees this.

Decomposition:
- Shared package sim_sched_pkg:
  - state enum: IDLE, DPRST, INHIB, START, WAIT, REPORT, NEXT, DONE, ABORT_RST.
  - result record struct: run, state, iter, timeout.
  - ITER_W = 10 constant.
- One sub-module, ko_list_ram: MAX_KO × LOG_RULES register file with one sync write port and one async read port, no reset.
- FSM, counters and result registers stay in the top.

Test Plan:
- Write list {3, 7}, num_ko = 2, go, res_ready = 1 → three results with runs 0, 1, 2. The INHIB strobe shows sel = 3 in run 1 and sel = 7 in run 2; no INHIB in run 0. Exactly one done pulse; busy is low afterwards.
- Model drives steady_state = 1 at iteration 12 → res_iter = 12, res_timeout = 0, and res_state equals dp_network_state in the capture cycle.
- Model never asserts steady → capture when iteration_number = 1000 with res_timeout = 1. Also drive steady and iteration = 1000 in the same cycle → res_timeout = 0.
- Hold res_ready = 0 for 5 cycles in REPORT → res_valid stays high and all fields are stable. The next run's dp_rst does not start until 1 cycle after the handshake.
- Assert abort during WAIT of run 1 → dp_rst high for 2 cycles, then IDLE with busy = 0, no done and no result for run 1. A following go restarts at run 0.
- num_ko = 20 with MAX_KO = 16 → 17 results. cfg_we while busy leaves the list unchanged. Async rst mid-WAIT clears all outputs immediately.
